// File: rtl/ysyx_22041207_lsu.sv
// Memory stage: turns execute load/store ops into data-bus transactions,
// aligns/extends load data and hands the result to write-back.
module ysyx_22041207_lsu #(
    parameter int unsigned RESP_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [2:0]  mem_op,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [63:0] bus_addr,
    output logic [7:0]  bus_wstrb,
    output logic [63:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [63:0] bus_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] ramdout,
    output logic        misalign,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [2:0]  off_q, off_d;
    logic        load_q, load_d;
    logic [31:0] cnt_q, cnt_d;
    logic        bus_req_d, bus_we_d, out_valid_d, misalign_d, bus_err_d;
    logic [63:0] bus_addr_d, bus_wdata_d, ramdout_d;
    logic [7:0]  bus_wstrb_d;

    logic        accept, is_mem, misal, timeout;
    logic [7:0]  mask;
    logic [2:0]  off;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid & in_ready;
    assign is_mem   = mem_ren | mem_wen;
    assign off      = addr[2:0];
    assign timeout  = (RESP_TIMEOUT != 0) && (cnt_q + 32'd1 == RESP_TIMEOUT);

    always_comb begin
        misal = 1'b0;
        mask  = 8'h01;
        unique case (mem_op[1:0])
            2'd0: mask = 8'h01;
            2'd1: begin mask = 8'h03; misal = addr[0]; end
            2'd2: begin mask = 8'h0F; misal = |addr[1:0]; end
            default: begin mask = 8'hFF; misal = |addr[2:0]; end
        endcase
    end

    function automatic logic [63:0] load_ext(input logic [2:0] op,
                                             input logic [2:0] o,
                                             input logic [63:0] rd);
        logic [63:0] d;
        d = rd >> {o, 3'b000};
        unique case (op)
            3'b000: load_ext = {{56{d[7]}}, d[7:0]};
            3'b100: load_ext = {56'd0, d[7:0]};
            3'b001: load_ext = {{48{d[15]}}, d[15:0]};
            3'b101: load_ext = {48'd0, d[15:0]};
            3'b010: load_ext = {{32{d[31]}}, d[31:0]};
            3'b110: load_ext = {32'd0, d[31:0]};
            default: load_ext = d;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = (is_mem && !misal) ? REQ : DONE;
            REQ:  if (bus_gnt) state_d = bus_rvalid ? DONE : RESP;
            RESP: if (bus_rvalid || timeout) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_d        = op_q;
        off_d       = off_q;
        load_d      = load_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req;
        bus_we_d    = bus_we;
        bus_addr_d  = bus_addr;
        bus_wstrb_d = bus_wstrb;
        bus_wdata_d = bus_wdata;
        out_valid_d = out_valid;
        ramdout_d   = ramdout;
        misalign_d  = misalign;
        bus_err_d   = bus_err;
        unique case (state_q)
            IDLE: if (accept) begin
                op_d       = mem_op;
                off_d      = off;
                load_d     = mem_ren;
                cnt_d      = 32'd0;
                ramdout_d  = 64'd0;
                misalign_d = 1'b0;
                bus_err_d  = 1'b0;
                if (!is_mem || misal) begin
                    out_valid_d = 1'b1;
                    misalign_d  = is_mem;
                end else begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = ~mem_ren;
                    bus_addr_d  = {addr[63:3], 3'b000};
                    bus_wstrb_d = mem_ren ? 8'h00 : (mask << off);
                    bus_wdata_d = wdata << {off, 3'b000};
                end
            end
            REQ: if (bus_gnt) begin
                bus_req_d = 1'b0;
                if (bus_rvalid) begin
                    out_valid_d = 1'b1;
                    ramdout_d   = load_q ? load_ext(op_q, off_q, bus_rdata) : 64'd0;
                end
            end
            RESP: begin
                if (bus_rvalid) begin
                    out_valid_d = 1'b1;
                    ramdout_d   = load_q ? load_ext(op_q, off_q, bus_rdata) : 64'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                    if (timeout) begin
                        out_valid_d = 1'b1;
                        bus_err_d   = 1'b1;
                        ramdout_d   = 64'd0;
                    end
                end
            end
            DONE: if (out_ready) begin
                out_valid_d = 1'b0;
                misalign_d  = 1'b0;
                bus_err_d   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= 3'd0;
            off_q     <= 3'd0;
            load_q    <= 1'b0;
            cnt_q     <= 32'd0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 64'd0;
            bus_wstrb <= 8'd0;
            bus_wdata <= 64'd0;
            out_valid <= 1'b0;
            ramdout   <= 64'd0;
            misalign  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            op_q      <= op_d;
            off_q     <= off_d;
            load_q    <= load_d;
            cnt_q     <= cnt_d;
            bus_req   <= bus_req_d;
            bus_we    <= bus_we_d;
            bus_addr  <= bus_addr_d;
            bus_wstrb <= bus_wstrb_d;
            bus_wdata <= bus_wdata_d;
            out_valid <= out_valid_d;
            ramdout   <= ramdout_d;
            misalign  <= misalign_d;
            bus_err   <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22041207_lsu.sv
// Bench for the LSU: directed vector table, reset/stray-response sequences,
// and random ops checked against an arithmetic reference model.
module tb_ysyx_22041207_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_ren = 1'b0;
    logic        mem_wen = 1'b0;
    logic [2:0]  mem_op = 3'd0;
    logic [63:0] addr = 64'd0;
    logic [63:0] wdata = 64'd0;
    logic        bus_req, bus_we;
    logic [63:0] bus_addr, bus_wdata;
    logic [7:0]  bus_wstrb;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [63:0] bus_rdata = 64'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] ramdout;
    logic        misalign, bus_err;

    int checks = 0;
    int failures = 0;

    ysyx_22041207_lsu #(.RESP_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_op(mem_op),
        .addr(addr), .wdata(wdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .ramdout(ramdout), .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic        ren;
        logic        wen;
        logic [63:0] a;
        logic [63:0] wd;
        logic [63:0] rd;
        int          gd;
        int          rsp;
        logic        same;
        int          rdy;
        logic        e_mis;
        logic        e_err;
        logic [63:0] e_ram;
        logic [63:0] e_addr;
        logic [7:0]  e_wstrb;
        logic [63:0] e_wdata;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic ren,
                                input logic wen, input logic [63:0] a,
                                input logic [63:0] wd, input logic [63:0] rd,
                                input int gd, input int rsp, input logic same,
                                input int rdy, input logic e_mis,
                                input logic e_err, input logic [63:0] e_ram,
                                input logic [63:0] e_addr,
                                input logic [7:0] e_wstrb,
                                input logic [63:0] e_wdata);
        vec_t v;
        v.op = op; v.ren = ren; v.wen = wen; v.a = a; v.wd = wd; v.rd = rd;
        v.gd = gd; v.rsp = rsp; v.same = same; v.rdy = rdy;
        v.e_mis = e_mis; v.e_err = e_err; v.e_ram = e_ram;
        v.e_addr = e_addr; v.e_wstrb = e_wstrb; v.e_wdata = e_wdata;
        return v;
    endfunction

    // Reference model: byte-count arithmetic, independent of the RTL datapath.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        longint unsigned nb, off, m, raw;
        logic st, bus;
        r = v;
        nb = 64'd1 << v.op[1:0];
        off = v.a % 8;
        st = v.wen && !v.ren;
        r.e_mis = (v.ren || v.wen) && (v.a % nb != 0);
        bus = (v.ren || v.wen) && !r.e_mis;
        r.e_err = bus && !v.same && (v.rsp >= TO);
        r.e_addr = v.a - off;
        r.e_wstrb = st ? 8'(((64'd1 << nb) - 1) << off) : 8'd0;
        r.e_wdata = v.wd << (8 * off);
        m = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 1);
        raw = (v.rd >> (8 * off)) & m;
        if (!v.op[2] && nb != 8 && raw[8 * nb - 1]) raw = raw | ~m;
        r.e_ram = (!bus || r.e_err || st) ? 64'd0 : raw;
        return r;
    endfunction

    task automatic run_op(input string tag, input vec_t v);
        logic bus;
        int n;
        bus = (v.ren || v.wen) && !v.e_mis;
        chk({tag, ":idle_ready"}, in_ready, 1);
        in_valid = 1'b1; mem_ren = v.ren; mem_wen = v.wen;
        mem_op = v.op; addr = v.a; wdata = v.wd;
        @(posedge clk); #1;
        in_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
        addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
        chk({tag, ":busy"}, in_ready, 0);
        if (!bus) begin
            chk({tag, ":no_req"}, bus_req, 0);
        end else begin
            chk({tag, ":req"}, bus_req, 1);
            chk({tag, ":we"}, bus_we, v.wen && !v.ren);
            chk({tag, ":addr"}, bus_addr, v.e_addr);
            chk({tag, ":wstrb"}, bus_wstrb, v.e_wstrb);
            if (v.wen && !v.ren) chk({tag, ":wdata"}, bus_wdata, v.e_wdata);
            repeat (v.gd) begin
                bus_rdata = {$urandom, $urandom};
                @(posedge clk); #1;
                chk({tag, ":req_hold"}, bus_req, 1);
                chk({tag, ":addr_hold"}, bus_addr, v.e_addr);
                chk({tag, ":ov_req"}, out_valid, 0);
            end
            bus_gnt = 1'b1; bus_rvalid = v.same; bus_rdata = v.rd;
            @(posedge clk); #1;
            bus_gnt = 1'b0; bus_rvalid = 1'b0;
            if (!v.same) begin
                chk({tag, ":req_drop"}, bus_req, 0);
                n = (v.rsp < TO) ? v.rsp + 1 : TO;
                for (int k = 1; k <= n; k++) begin
                    chk({tag, ":ov_resp"}, out_valid, 0);
                    if (k == n && !v.e_err) begin
                        bus_rvalid = 1'b1; bus_rdata = v.rd;
                    end else begin
                        bus_rdata = {$urandom, $urandom};
                    end
                    @(posedge clk); #1;
                    bus_rvalid = 1'b0;
                end
            end
        end
        for (int k = 0; k <= v.rdy; k++) begin
            if (k != 0) begin
                @(posedge clk); #1;
                chk({tag, ":hold_busy"}, in_ready, 0);
            end
            chk({tag, ":ov"}, out_valid, 1);
            chk({tag, ":misalign"}, misalign, v.e_mis);
            chk({tag, ":bus_err"}, bus_err, v.e_err);
            chk({tag, ":ramdout"}, ramdout, v.e_ram);
            chk({tag, ":req_done"}, bus_req, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ":ov_clr"}, out_valid, 0);
        chk({tag, ":ready_back"}, in_ready, 1);
        chk({tag, ":mis_clr"}, misalign, 0);
        chk({tag, ":err_clr"}, bus_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[13];
        vec_t v;
        tbl[0]  = mk(3'b000, 1, 0, 64'h8000_0005, 0, 64'h0000_80FF_0000_0000,
                     0, 1, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FF80,
                     64'h8000_0000, 8'h00, 0);
        tbl[1]  = mk(3'b100, 1, 0, 64'h8000_0005, 0, 64'h0000_80FF_0000_0000,
                     1, 1, 0, 1, 0, 0, 64'h80, 64'h8000_0000, 8'h00, 0);
        tbl[2]  = mk(3'b001, 0, 1, 64'h1002, 64'hABCD, 64'hDEAD_BEEF_DEAD_BEEF,
                     0, 0, 0, 0, 0, 0, 0, 64'h1000, 8'h0C, 64'hABCD_0000);
        tbl[3]  = mk(3'b010, 1, 0, 64'h1006, 0, 0,
                     0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[4]  = mk(3'b011, 1, 0, 64'h2000, 0, 64'h1122_3344_5566_7788,
                     0, 0, 1, 3, 0, 0, 64'h1122_3344_5566_7788,
                     64'h2000, 8'h00, 0);
        tbl[5]  = mk(3'b000, 0, 0, 64'h3, 0, 0,
                     0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(3'b001, 1, 0, 64'h3, 0, 0,
                     0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        tbl[7]  = mk(3'b110, 1, 0, 64'h4, 0, 64'h8765_4321_0000_0000,
                     2, 2, 0, 0, 0, 0, 64'h8765_4321, 64'h0, 8'h00, 0);
        tbl[8]  = mk(3'b010, 1, 0, 64'h4, 0, 64'h8765_4321_0000_0000,
                     0, 3, 0, 0, 0, 0, 64'hFFFF_FFFF_8765_4321,
                     64'h0, 8'h00, 0);
        tbl[9]  = mk(3'b011, 0, 1, 64'h10, 64'h0123_4567_89AB_CDEF, 0,
                     1, 1, 0, 0, 0, 0, 0, 64'h10, 8'hFF,
                     64'h0123_4567_89AB_CDEF);
        tbl[10] = mk(3'b000, 1, 1, 64'h7, 64'hFF, 64'h7F00_0000_0000_0000,
                     0, 0, 0, 0, 0, 0, 64'h7F, 64'h0, 8'h00, 0);
        tbl[11] = mk(3'b111, 1, 0, 64'h8, 0, 64'hFEDC_BA98_7654_3210,
                     0, 0, 1, 0, 0, 0, 64'hFEDC_BA98_7654_3210,
                     64'h8, 8'h00, 0);
        tbl[12] = mk(3'b000, 0, 1, 64'h5, 64'h1FF, 0,
                     0, 2, 0, 0, 0, 0, 0, 64'h0, 8'h20,
                     64'h0001_FF00_0000_0000);

        #3;
        chk("rst_req", bus_req, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_ram", ramdout, 0);
        chk("rst_wstrb", bus_wstrb, 0);
        chk("rst_addr", bus_addr, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) run_op($sformatf("vec%0d", i), tbl[i]);

        run_op("timeout", mk(3'b011, 1, 0, 64'h40, 0, 0, 0, 9, 0, 0,
                             0, 1, 0, 64'h40, 8'h00, 0));
        bus_rvalid = 1'b1; bus_rdata = 64'hCAFE_F00D_CAFE_F00D;
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        chk("stray_ov", out_valid, 0);
        chk("stray_ready", in_ready, 1);
        chk("stray_ram", ramdout, 0);

        in_valid = 1'b1; mem_ren = 1'b1; mem_op = 3'b011; addr = 64'h100;
        @(posedge clk); #1;
        in_valid = 1'b0; mem_ren = 1'b0;
        chk("midreq_req", bus_req, 1);
        rst_n = 1'b0;
        #1;
        chk("midreq_rst_req", bus_req, 0);
        chk("midreq_rst_ov", out_valid, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("midreq_ready", in_ready, 1);
            chk("midreq_ov", out_valid, 0);
            chk("midreq_req_off", bus_req, 0);
            @(posedge clk); #1;
        end

        for (int i = 0; i < 80; i++) begin
            v.op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: begin v.ren = 0; v.wen = 0; end
                1: begin v.ren = 1; v.wen = 1; end
                2, 3: begin v.ren = 1; v.wen = 0; end
                default: begin v.ren = 0; v.wen = 1; end
            endcase
            v.a = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0)
                v.a = v.a & ~((64'd1 << v.op[1:0]) - 1);
            v.wd = {$urandom, $urandom};
            v.rd = {$urandom, $urandom};
            v.gd = $urandom_range(0, 3);
            v.rsp = $urandom_range(0, 5);
            v.same = ($urandom_range(0, 3) == 0);
            v.rdy = $urandom_range(0, 2);
            run_op($sformatf("rnd%0d", i), model(v));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_22041207_lsu.md
Name: ysyx_22041207_lsu

Overview:
Load/store unit forming the memory stage directly upstream of write-back. It accepts one memory op per handshake from execute, using the ALU result as the address. It runs a request/response transaction on the data-memory bus and aligns and extends load data. It then presents the 64-bit ramdout to write-back with a valid/ready handshake.

Parameters:
RESP_TIMEOUT, 0, cycles allowed in RESP before the access is aborted with bus_err; 0 disables the timeout.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  op presented by execute
in_ready  out  1  LSU can accept an op
mem_ren  in  1  load
mem_wen  in  1  store (mem_ren=mem_wen=1 is illegal; treated as load)
mem_op  in  3  funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
addr  in  64  effective address (alu_c)
wdata  in  64  store data, LSBs significant
bus_req  out  1  bus request
bus_we  out  1  1=write
bus_addr  out  64  {addr[63:3],3'b000}
bus_wstrb  out  8  byte enables
bus_wdata  out  64  lane-shifted store data
bus_gnt  in  1  request accepted
bus_rvalid  in  1  response (read data or write ack)
bus_rdata  in  64  read data, aligned doubleword
out_valid  out  1  result valid to write-back
out_ready  in  1  write-back accepts
ramdout  out  64  extended load data, 0 for stores/no-op/faults
misalign  out  1  access faulted on alignment, qualified by out_valid
bus_err  out  1  access timed out, qualified by out_valid

Behaviour:
- Reset (async, rst_n=0): state IDLE. bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata, out_valid, ramdout, misalign, bus_err and timeout counter all 0. bus_req deasserts immediately, even mid-transaction. The in-flight op is dropped.
- All outputs are registered except in_ready, which is 1 iff state==IDLE.
- Accept = in_valid & in_ready. The op fields are captured in the accept cycle.
- Size = mem_op[1:0]. Misaligned means:
  - H with addr[0]!=0
  - W with addr[1:0]!=0
  - D with addr[2:0]!=0
- FSM:
  - IDLE, accept with no ren/wen -> DONE; ramdout=0. Latency 1.
  - IDLE, accept misaligned -> DONE; misalign=1, ramdout=0, no bus activity.
  - IDLE, accept otherwise -> REQ; drive bus_req=1, bus_we=wen, bus_addr, bus_wstrb, bus_wdata.
  - REQ: hold all bus outputs stable until bus_gnt. On gnt, drop bus_req next cycle and go RESP. If gnt and rvalid arrive in the same cycle, complete directly to DONE.
  - RESP: wait for bus_rvalid, then go DONE. Loads capture the extended data; stores set ramdout=0.
  - RESP timeout: the counter increments each RESP cycle. If RESP_TIMEOUT!=0 and the count reaches RESP_TIMEOUT without rvalid, go DONE with bus_err=1, ramdout=0.
  - DONE: out_valid=1; ramdout/misalign/bus_err held until out_ready. On out_ready go IDLE and clear out_valid, misalign, bus_err.
- Store lanes: off=addr[2:0].
  - bus_wstrb = ({1,3,15,255}[size]) << off.
  - bus_wdata = wdata << (8*off).
  - bus_we=0 and bus_wstrb=0 for loads.
- Load extraction: d = bus_rdata >> (8*off), then:
  - B: sign-extend d[7:0]; BU: zero-extend d[7:0]
  - H: sign-extend d[15:0]; HU: zero-extend d[15:0]
  - W: sign-extend d[31:0]; WU: zero-extend d[31:0]
  - D: d
  - mem_op 111 behaves as D.
- bus_rvalid outside RESP/REQ-completion is ignored. in_valid outside IDLE is ignored; execute must hold it.
- Throughput: at most one op per 2 cycles (no-op). A bus access takes at least 3 cycles.

Test Plan:
- Reset mid-REQ: rst_n=0 while bus_req=1 -> bus_req=0 at once, in_ready=1 after release, out_valid never pulses.
- LB addr=0x8000_0005, bus_rdata=0x0000_80FF_0000_0000, gnt then rvalid 2 cycles later -> ramdout=0xFFFF_FFFF_FFFF_FF80. LBU on the same data -> 0x0000_0000_0000_0080.
- SH addr=0x1002, wdata=0xABCD -> bus_addr=0x1000, wstrb=0x0C, wdata=0x0000_0000_ABCD_0000, we=1. DONE after rvalid with ramdout=0.
- LW addr=0x1006 -> no bus_req, next cycle out_valid=1, misalign=1, ramdout=0.
- gnt and rvalid same cycle for LD data 0x1122_3344_5566_7788 -> out_valid the following cycle, ramdout=0x1122_3344_5566_7788. Hold out_ready=0 for 3 cycles -> outputs stable, in_ready=0.
- RESP_TIMEOUT=4, rvalid never arrives -> out_valid with bus_err=1 exactly 4 cycles after entering RESP. A later stray rvalid in IDLE has no effect.
